// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: bus widths, FSM state encoding, lane-enable helper.
// Byte positions count from the requested address; position 0 is the most significant byte.
package mem_responder_pkg;

  localparam int DATA_BUS = 64;
  localparam int ADDR_BUS = 32;

  typedef logic [1:0] mem_rsp_state_t;
  localparam mem_rsp_state_t ST_IDLE   = 2'd0;
  localparam mem_rsp_state_t ST_ACC_LO = 2'd1;
  localparam mem_rsp_state_t ST_ACC_HI = 2'd2;
  localparam mem_rsp_state_t ST_DONE   = 2'd3;

  // Byte-enable bit b covers RAM word bits [8b+7:8b]; lane k of a word lives in bits [63-8k -: 8].
  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
  } lane_mask_t;

  // Two-word window of 16 lanes; the selected run starts at lane and is width bytes long.
  function automatic lane_mask_t lane_mask(input logic [2:0] lane, input logic [3:0] width);
    logic [15:0] m;
    m = ~(16'hFFFF >> width) >> lane;
    return m;
  endfunction

endpackage

// File: rtl/mem_bram_be.sv
// Single-port synchronous RAM, DEPTH_WORDS x DATA_W, per-byte write enables, 1-cycle read latency.
// Contents are never cleared by reset.
module mem_bram_be #(
  parameter int    DATA_W      = 64,
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = "",
  localparam int   AW          = $clog2(DEPTH_WORDS),
  localparam int   NB          = DATA_W / 8
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [NB-1:0]     be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < NB; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Serves one proc memory-port request at a time against the table RAM, splitting word-spanning
// accesses in two. Latency ce->ready: 3 (single word), 4 (spanning), 2 (illegal); no queueing.
import mem_responder_pkg::*;

module mem_responder #(
  parameter int    DATA_W      = DATA_BUS,
  parameter int    ADDR_W      = ADDR_BUS,
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        mem_width_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_ready_o,
  output logic              mem_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int WW = ADDR_W - 3;
  localparam logic [WW:0] DEPTH_L = (WW+1)'(DEPTH_WORDS);

  logic [WW-1:0]       in_word;
  logic [2:0]          in_lane;
  logic                in_span;
  logic                in_bad;
  lane_mask_t          in_mask;
  logic [6:0]          in_wsh;
  logic [2*DATA_W-1:0] in_wimg;

  mem_rsp_state_t      state_q, state_d;
  logic                we_q, span_q;
  logic [2:0]          lane_q;
  logic [3:0]          width_q;
  logic [AW-1:0]       word_q, word_hi;
  logic [7:0]          hi_be_q;
  logic [DATA_W-1:0]   hi_wdat_q, lo_rd_q;
  logic                ready_q, err_q;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                ram_en, ram_we;
  logic [7:0]          ram_be;
  logic [AW-1:0]       ram_addr;
  logic [DATA_W-1:0]   ram_wdat, ram_rdat;

  logic [2*DATA_W-1:0] rd_img, rd_al;
  logic [7:0]          rd_rsh;

  assign in_word = mem_addr_i[ADDR_W-1:3];
  assign in_lane = mem_addr_i[2:0];
  assign in_span = ({2'b00, in_lane} + {1'b0, mem_width_i}) > 5'd8;
  assign in_bad  = (mem_width_i == 4'd0) || (mem_width_i > 4'd8) ||
                   ({1'b0, in_word} >= DEPTH_L) ||
                   (in_span && (({1'b0, in_word} + {{WW{1'b0}}, 1'b1}) >= DEPTH_L));
  assign in_mask = lane_mask(in_lane, mem_width_i);

  // Left-justify the right-aligned write data, then slide it to its lane in the two-word window.
  assign in_wsh  = 7'(DATA_W) - {mem_width_i, 3'b000};
  assign in_wimg = ({mem_data_i, {DATA_W{1'b0}}} << in_wsh) >> {in_lane, 3'b000};

  assign word_hi = word_q + {{(AW-1){1'b0}}, 1'b1};

  // In ACC_HI the RAM output is the high word, so the low word comes from the capture register.
  assign rd_img = {(state_q == ST_ACC_HI) ? lo_rd_q : ram_rdat, ram_rdat};
  assign rd_rsh = 8'(2*DATA_W) - {1'b0, width_q, 3'b000};
  assign rd_al  = (rd_img << {lane_q, 3'b000}) >> rd_rsh;

  always_comb begin
    state_d  = state_q;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_be   = '0;
    ram_addr = in_word[AW-1:0];
    ram_wdat = in_wimg[2*DATA_W-1:DATA_W];
    data_d   = data_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_ce_i) begin
          if (in_bad) begin
            state_d = ST_DONE;
            data_d  = '0;
          end else begin
            ram_en  = 1'b1;
            ram_we  = mem_we_i;
            ram_be  = in_mask.lo;
            state_d = ST_ACC_LO;
          end
        end
      end
      ST_ACC_LO: begin
        if (span_q) begin
          // High-word writes wait for ACC_HI so a reset there leaves the high word untouched.
          ram_en   = !we_q;
          ram_addr = word_hi;
          state_d  = ST_ACC_HI;
        end else begin
          data_d  = we_q ? '0 : rd_al[DATA_W-1:0];
          state_d = ST_DONE;
        end
      end
      ST_ACC_HI: begin
        ram_en   = we_q;
        ram_we   = we_q;
        ram_be   = hi_be_q;
        ram_addr = word_hi;
        ram_wdat = hi_wdat_q;
        data_d   = we_q ? '0 : rd_al[DATA_W-1:0];
        state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_DONE);
      err_q   <= (state_q == ST_IDLE) && (state_d == ST_DONE);
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && mem_ce_i) begin
      we_q      <= mem_we_i;
      span_q    <= in_span;
      lane_q    <= in_lane;
      width_q   <= mem_width_i;
      word_q    <= in_word[AW-1:0];
      hi_be_q   <= in_mask.hi;
      hi_wdat_q <= in_wimg[DATA_W-1:0];
    end
    if (state_q == ST_ACC_LO) lo_rd_q <= ram_rdat;
  end

  mem_bram_be #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en && !rst),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdat),
    .rdata_o (ram_rdat)
  );

  assign mem_ready_o = ready_q;
  assign mem_err_o   = err_q;
  assign mem_data_o  = data_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: byte-array reference model, scoreboard queue, negedge monitor.
module tb_mem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst, ce, we;
  logic [31:0] addr;
  logic [3:0]  width;
  logic [63:0] wdata, rdata;
  logic        ready, err;

  mem_responder #(
    .DATA_W(64), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .mem_ce_i(ce), .mem_we_i(we), .mem_addr_i(addr),
    .mem_width_i(width), .mem_data_i(wdata), .mem_data_o(rdata),
    .mem_ready_o(ready), .mem_err_o(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
    int          issue;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [7:0]  mdl [DEPTH*8];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_rdy = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h required 0x%016h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a, input logic [3:0] w);
    int unsigned word = a >> 3;
    int unsigned lane = a & 32'd7;
    return (w == 0) || (w > 8) || (word >= DEPTH) || ((lane + w > 8) && (word + 1 >= DEPTH));
  endfunction

  // Issue one request right after a posedge; returns #1 after the edge on which ready was seen.
  task automatic run_req(input bit w_e, input logic [31:0] a, input logic [3:0] w, input logic [63:0] d);
    exp_t e;
    bit   got;
    int   wi;
    wi = int'(w);
    ce = 1'b1; we = w_e; addr = a; width = w; wdata = d;
    e.issue = cyc;
    e.data  = '0;
    if (is_bad(a, w)) begin
      e.err = 1'b1;
      e.lat = 2;
    end else begin
      e.err = 1'b0;
      e.lat = ((a % 8) + wi > 8) ? 4 : 3;
      for (int j = 0; j < wi; j++) begin
        if (w_e) mdl[a+j] = d[8*(wi-1-j) +: 8];
        else     e.data   = (e.data << 8) | 64'(mdl[a+j]);
      end
    end
    sbq.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      got = ready;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: no ready for addr 0x%08h width %0d", a, w);
      if (sbq.size() > 0) void'(sbq.pop_back());
    end
    @(posedge clk);
    #1;
    ce = 1'b0;
  endtask

  always @(negedge clk) begin
    if (ready) begin
      n_rdy++;
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready: ready=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        mon_e = sbq.pop_front();
        check64("rsp_data", rdata, mon_e.data);
        check64("rsp_err", {63'b0, err}, {63'b0, mon_e.err});
        check64("rsp_latency", 64'(cyc - mon_e.issue + 1), 64'(mon_e.lat));
      end
    end
  end

  initial begin
    int base;
    int n;
    logic [31:0] ra;
    logic [3:0]  rw;
    int          r;

    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; width = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check64("reset_ready", {63'b0, ready}, 64'd0);
    check64("reset_err", {63'b0, err}, 64'd0);
    check64("reset_data", rdata, 64'd0);
    @(posedge clk);
    #1;

    // Known contents for words 0..64 and the last word.
    for (int w = 0; w <= 64; w++) run_req(1'b1, 32'(w*8), 4'd8, {$urandom, $urandom});
    run_req(1'b1, 32'((DEPTH-1)*8), 4'd8, {$urandom, $urandom});

    run_req(1'b1, 32'h40, 4'd8, 64'h0011223344556677);
    run_req(1'b0, 32'h40, 4'd8, '0);
    run_req(1'b1, 32'h46, 4'd4, 64'hFFFF_FFFF_AABBCCDD);
    run_req(1'b0, 32'h47, 4'd2, '0);
    run_req(1'b0, 32'h40, 4'd6, '0);
    run_req(1'b0, 32'h43, 4'd1, '0);

    run_req(1'b1, 32'h40, 4'd0, '1);
    run_req(1'b1, 32'h40, 4'd9, '1);
    run_req(1'b0, 32'(DEPTH*8), 4'd1, '0);
    run_req(1'b1, 32'((DEPTH-1)*8+4), 4'd8, '1);
    run_req(1'b0, 32'h40, 4'd8, '0);
    run_req(1'b0, 32'((DEPTH-1)*8), 4'd8, '0);
    run_req(1'b0, 32'((DEPTH-1)*8+7), 4'd1, '0);

    base = n_rdy;
    run_req(1'b0, 32'h10, 4'd8, '0);
    run_req(1'b0, 32'h1D, 4'd5, '0);
    run_req(1'b0, 32'h22, 4'd3, '0);
    repeat (4) @(posedge clk);
    check64("b2b_ready_count", 64'(n_rdy - base), 64'd3);
    #1;

    // Reset lands in ACC_HI of a spanning write: low word committed, high word untouched.
    run_req(1'b1, 32'h40, 4'd8, 64'h0011223344556677);
    run_req(1'b1, 32'h48, 4'd8, 64'h8899AABBCCDDEEFF);
    run_req(1'b0, 32'h40, 4'd8, '0);
    base = n_rdy;
    ce = 1'b1; we = 1'b1; addr = 32'h46; width = 4'd4; wdata = 64'hAABBCCDD;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1; ce = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check64("rst_mid_ready", {63'b0, ready}, 64'd0);
    check64("rst_mid_err", {63'b0, err}, 64'd0);
    check64("rst_mid_data", rdata, 64'd0);
    mdl[32'h46] = 8'hAA;
    mdl[32'h47] = 8'hBB;
    repeat (2) @(posedge clk);
    check64("rst_mid_no_ready", 64'(n_rdy - base), 64'd0);
    #1;
    run_req(1'b0, 32'h46, 4'd3, '0);

    for (int k = 0; k < 300; k++) begin
      n = $urandom_range(0, 2);
      if (n > 0) begin
        repeat (n) @(posedge clk);
        #1;
      end
      r  = $urandom_range(0, 19);
      ra = $urandom_range(0, 'h1FF);
      rw = 4'($urandom_range(1, 8));
      if (r == 0) rw = 4'd0;
      if (r == 1) rw = 4'($urandom_range(9, 15));
      if (r == 2) ra = 32'(DEPTH*8) + $urandom_range(0, 100);
      run_req(1'($urandom_range(0, 1)), ra, rw, {$urandom, $urandom});
    end

    repeat (5) @(posedge clk);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
